// File: rtl/scpu_pkg.sv
// scpu_pkg: constants and helpers shared across the scpu pipeline stages
package scpu_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    localparam int CTRL_W            = 12;
    localparam int CTRL_REG_WRITE    = 11;
    localparam int CTRL_MEM_READ     = 10;
    localparam int CTRL_MEM_WRITE    = 9;
    localparam int CTRL_MEM_TO_REG_H = 8;
    localparam int CTRL_MEM_TO_REG_L = 7;
    localparam int CTRL_ALU_SRC      = 6;
    localparam int CTRL_ALU_OP_H     = 5;
    localparam int CTRL_ALU_OP_L     = 2;
    localparam int CTRL_BRANCH       = 1;
    localparam int CTRL_JUMP         = 0;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [1:0] {
        ACT_HOLD   = 2'd0,
        ACT_FLUSH  = 2'd1,
        ACT_BUBBLE = 2'd2,
        ACT_PASS   = 2'd3
    } idex_action_e;

    // Stall beats flush beats load-use bubble; otherwise the ID fields pass through.
    function automatic idex_action_e idex_action(input logic stall, input logic flush, input logic zero);
        return stall ? ACT_HOLD : flush ? ACT_FLUSH : zero ? ACT_BUBBLE : ACT_PASS;
    endfunction

endpackage

// File: rtl/idex_pipeline_reg_event_counter.sv
// event_counter: free-running wrapping event counter with enable and sync active-low reset
module event_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_en,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Count enabled events, wrapping naturally at 2^WIDTH.
    always_ff @(posedge clk) begin
        if (!rstn) r_count <= '0;
        else if (i_en) r_count <= r_count + 1'b1;
    end

    assign o_count = r_count;

endmodule

// File: rtl/idex_pipeline_reg.sv
// idex_pipeline_reg: ID/EX pipeline register with stall, flush, load-use bubble and event counters
module idex_pipeline_reg
    import scpu_pkg::*;
#(
    parameter int          XLEN      = 32,
    parameter int          CNT_WIDTH = 32,
    parameter logic [31:0] NOP_INST  = scpu_pkg::NOP_INST
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 idexin_stall,
    input  logic                 idexin_flush,
    input  logic                 idexin_zero,
    input  logic                 idexin_valid,
    input  logic [XLEN-1:0]      idexin_pc,
    input  logic [31:0]          idexin_inst,
    input  logic [XLEN-1:0]      idexin_rs1_data,
    input  logic [XLEN-1:0]      idexin_rs2_data,
    input  logic [XLEN-1:0]      idexin_imm,
    input  logic [4:0]           idexin_rs1_addr,
    input  logic [4:0]           idexin_rs2_addr,
    input  logic [4:0]           idexin_rd_addr,
    input  logic [CTRL_W-1:0]    idexin_ctrl,
    output logic                 idexout_valid,
    output logic [XLEN-1:0]      idexout_pc,
    output logic [31:0]          idexout_inst,
    output logic [XLEN-1:0]      idexout_rs1_data,
    output logic [XLEN-1:0]      idexout_rs2_data,
    output logic [XLEN-1:0]      idexout_imm,
    output logic [4:0]           idexout_rs1_addr,
    output logic [4:0]           idexout_rs2_addr,
    output logic [4:0]           idexout_rd_addr,
    output logic [CTRL_W-1:0]    idexout_ctrl,
    output logic [CNT_WIDTH-1:0] idexout_bubble_cnt,
    output logic [CNT_WIDTH-1:0] idexout_flush_cnt
);

    idex_action_e w_action;
    logic         w_load_bubble;
    logic         w_load_pass;
    logic         w_flush_evt;
    logic         w_bubble_evt;

    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [31:0]       r_inst;
    logic [XLEN-1:0]   r_rs1_data;
    logic [XLEN-1:0]   r_rs2_data;
    logic [XLEN-1:0]   r_imm;
    logic [4:0]        r_rs1_addr;
    logic [4:0]        r_rs2_addr;
    logic [4:0]        r_rd_addr;
    logic [CTRL_W-1:0] r_ctrl;

    assign w_action      = idex_action(idexin_stall, idexin_flush, idexin_zero);
    assign w_flush_evt   = (w_action == ACT_FLUSH);
    assign w_bubble_evt  = (w_action == ACT_BUBBLE);
    assign w_load_bubble = w_flush_evt | w_bubble_evt;
    assign w_load_pass   = (w_action == ACT_PASS);

    // Pipeline state: reset and bubble both load a NOP; hold is the implicit default.
    always_ff @(posedge clk) begin
        if (!rstn || w_load_bubble) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_inst     <= NOP_INST;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_rs1_addr <= '0;
            r_rs2_addr <= '0;
            r_rd_addr  <= '0;
            r_ctrl     <= '0;
        end else if (w_load_pass) begin
            r_valid    <= idexin_valid;
            r_pc       <= idexin_pc;
            r_inst     <= idexin_inst;
            r_rs1_data <= idexin_rs1_data;
            r_rs2_data <= idexin_rs2_data;
            r_imm      <= idexin_imm;
            r_rs1_addr <= idexin_rs1_addr;
            r_rs2_addr <= idexin_rs2_addr;
            r_rd_addr  <= idexin_rd_addr;
            r_ctrl     <= idexin_ctrl;
        end
    end

    event_counter #(.WIDTH(CNT_WIDTH)) u_bubble_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_bubble_evt),
        .o_count (idexout_bubble_cnt)
    );

    event_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .i_en    (w_flush_evt),
        .o_count (idexout_flush_cnt)
    );

    assign idexout_valid    = r_valid;
    assign idexout_pc       = r_pc;
    assign idexout_inst     = r_inst;
    assign idexout_rs1_data = r_rs1_data;
    assign idexout_rs2_data = r_rs2_data;
    assign idexout_imm      = r_imm;
    assign idexout_rs1_addr = r_rs1_addr;
    assign idexout_rs2_addr = r_rs2_addr;
    assign idexout_rd_addr  = r_rd_addr;
    assign idexout_ctrl     = r_ctrl;

endmodule

// File: tb/tb_idex_pipeline_reg.sv
// tb_idex_pipeline_reg: directed self-checking bench for the ID/EX pipeline register
module tb_idex_pipeline_reg;

    logic        clk;
    logic        rstn;
    logic        stall, flush, zero, valid;
    logic [31:0] pc, inst, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [11:0] ctrl;

    logic        o_valid, n_valid;
    logic [31:0] o_pc, o_inst, o_rs1_data, o_rs2_data, o_imm;
    logic [31:0] n_pc, n_inst, n_rs1_data, n_rs2_data, n_imm;
    logic [4:0]  o_rs1_addr, o_rs2_addr, o_rd_addr, n_rs1_addr, n_rs2_addr, n_rd_addr;
    logic [11:0] o_ctrl, n_ctrl;
    logic [31:0] o_bcnt, o_fcnt;
    logic [3:0]  n_bcnt, n_fcnt;

    int n_cmp = 0;
    int n_err = 0;

    idex_pipeline_reg dut (
        .clk(clk), .rstn(rstn), .idexin_stall(stall), .idexin_flush(flush), .idexin_zero(zero),
        .idexin_valid(valid), .idexin_pc(pc), .idexin_inst(inst), .idexin_rs1_data(rs1_data),
        .idexin_rs2_data(rs2_data), .idexin_imm(imm), .idexin_rs1_addr(rs1_addr),
        .idexin_rs2_addr(rs2_addr), .idexin_rd_addr(rd_addr), .idexin_ctrl(ctrl),
        .idexout_valid(o_valid), .idexout_pc(o_pc), .idexout_inst(o_inst),
        .idexout_rs1_data(o_rs1_data), .idexout_rs2_data(o_rs2_data), .idexout_imm(o_imm),
        .idexout_rs1_addr(o_rs1_addr), .idexout_rs2_addr(o_rs2_addr), .idexout_rd_addr(o_rd_addr),
        .idexout_ctrl(o_ctrl), .idexout_bubble_cnt(o_bcnt), .idexout_flush_cnt(o_fcnt)
    );

    idex_pipeline_reg #(.CNT_WIDTH(4)) dut_w (
        .clk(clk), .rstn(rstn), .idexin_stall(stall), .idexin_flush(flush), .idexin_zero(zero),
        .idexin_valid(valid), .idexin_pc(pc), .idexin_inst(inst), .idexin_rs1_data(rs1_data),
        .idexin_rs2_data(rs2_data), .idexin_imm(imm), .idexin_rs1_addr(rs1_addr),
        .idexin_rs2_addr(rs2_addr), .idexin_rd_addr(rd_addr), .idexin_ctrl(ctrl),
        .idexout_valid(n_valid), .idexout_pc(n_pc), .idexout_inst(n_inst),
        .idexout_rs1_data(n_rs1_data), .idexout_rs2_data(n_rs2_data), .idexout_imm(n_imm),
        .idexout_rs1_addr(n_rs1_addr), .idexout_rs2_addr(n_rs2_addr), .idexout_rd_addr(n_rd_addr),
        .idexout_ctrl(n_ctrl), .idexout_bubble_cnt(n_bcnt), .idexout_flush_cnt(n_fcnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] p, input logic [31:0] in, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] im, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [4:0] rd, input logic [11:0] c, input logic v);
        pc = p; inst = in; rs1_data = a; rs2_data = b; imm = im;
        rs1_addr = r1; rs2_addr = r2; rd_addr = rd; ctrl = c; valid = v;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".valid"}, {31'd0, o_valid}, 32'd0);
        chk({tag, ".pc"}, o_pc, 32'd0);
        chk({tag, ".inst"}, o_inst, 32'h00000013);
        chk({tag, ".data"}, o_rs1_data | o_rs2_data | o_imm, 32'd0);
        chk({tag, ".addr"}, {17'd0, o_rs1_addr, o_rs2_addr, o_rd_addr}, 32'd0);
        chk({tag, ".ctrl"}, {20'd0, o_ctrl}, 32'd0);
    endtask

    task automatic chk_cnt(input string tag, input int b, input int f, input int nb, input int nf);
        chk({tag, ".bcnt"}, o_bcnt, b);
        chk({tag, ".fcnt"}, o_fcnt, f);
        chk({tag, ".bcnt4"}, {28'd0, n_bcnt}, nb);
        chk({tag, ".fcnt4"}, {28'd0, n_fcnt}, nf);
    endtask

    initial begin
        rstn = 1'b0; stall = 1'b1; flush = 1'b1; zero = 1'b1;
        drive($urandom, $urandom, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
              5'($urandom), 12'($urandom), 1'b1);
        step();
        step();
        chk_bubble("reset");
        chk_cnt("reset", 0, 0, 0, 0);

        rstn = 1'b1; stall = 1'b0; flush = 1'b0; zero = 1'b0;
        drive(32'h100, 32'h00208033, 32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003,
              5'd1, 5'd2, 5'd1, 12'h800, 1'b1);
        step();
        chk("norm.valid", {31'd0, o_valid}, 32'd1);
        chk("norm.pc", o_pc, 32'h100);
        chk("norm.inst", o_inst, 32'h00208033);
        chk("norm.rs1d", o_rs1_data, 32'hAAAA_0001);
        chk("norm.rs2d", o_rs2_data, 32'hBBBB_0002);
        chk("norm.imm", o_imm, 32'hCCCC_0003);
        chk("norm.addr", {17'd0, o_rs1_addr, o_rs2_addr, o_rd_addr}, {17'd0, 5'd1, 5'd2, 5'd1});
        chk("norm.ctrl", {20'd0, o_ctrl}, 32'h800);
        chk_cnt("norm", 0, 0, 0, 0);

        drive(32'h104, 32'h0000A103, 32'h11, 32'h22, 32'h0, 5'd1, 5'd0, 5'd2, 12'hC00, 1'b1);
        zero = 1'b1;
        step();
        chk_bubble("lduse");
        chk_cnt("lduse", 1, 0, 1, 0);
        zero = 1'b0;
        step();
        chk("lduse.next.pc", o_pc, 32'h104);
        chk("lduse.next.valid", {31'd0, o_valid}, 32'd1);
        chk("lduse.next.ctrl", {20'd0, o_ctrl}, 32'hC00);
        chk("lduse.next.rd", {27'd0, o_rd_addr}, 32'd2);

        stall = 1'b1; flush = 1'b1; zero = 1'b1;
        drive(32'h108, 32'h00000033, 32'h5, 32'h6, 32'h7, 5'd3, 5'd4, 5'd5, 12'h801, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall.pc", o_pc, 32'h104);
            chk("stall.inst", o_inst, 32'h0000A103);
            chk("stall.valid", {31'd0, o_valid}, 32'd1);
            chk_cnt("stall", 1, 0, 1, 0);
        end
        stall = 1'b0;
        step();
        chk_bubble("unstall_flush");
        chk_cnt("unstall_flush", 1, 1, 1, 1);

        flush = 1'b0; zero = 1'b0;
        step();
        chk("reload.pc", o_pc, 32'h108);
        chk("reload.ctrl", {20'd0, o_ctrl}, 32'h801);
        flush = 1'b1; zero = 1'b1;
        step();
        chk_bubble("flush_zero");
        chk_cnt("flush_zero", 1, 2, 1, 2);

        flush = 1'b0; zero = 1'b0;
        drive(32'h200, 32'h00000013, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 12'h5A5, 1'b0);
        step();
        chk("inval.valid", {31'd0, o_valid}, 32'd0);
        chk("inval.ctrl", {20'd0, o_ctrl}, 32'h5A5);
        chk("inval.pc", o_pc, 32'h200);

        stall = 1'b1; zero = 1'b1; rstn = 1'b0;
        step();
        chk_bubble("rst_mid");
        chk_cnt("rst_mid", 0, 0, 0, 0);

        rstn = 1'b1; stall = 1'b0; zero = 1'b1;
        for (int i = 0; i < 17; i++) step();
        chk_cnt("wrap", 17, 0, 1, 0);
        chk_bubble("wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
